fetch_inst_queue: RTL and testbench

- Decoupling FIFO between the fetch stage (PC from the branch target buffer plus instruction memory read) and the decode stage.
- Each entry holds one fetched instruction with its PC and the BTB prediction bit, so decode and execute can later resolve the branch against it.
- A BTB misprediction flush discards all wrong-path entries in one cycle.
- Fetch back-pressure is provided by the ready signal.

---
 rtl/fetch_inst_queue.sv | 98 +++++++++
 tb/tb_fetch_inst_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue.
// Holds fetched instructions with their PC and BTB predicted-taken bit until
// decode takes them. A misprediction flush empties the queue in one cycle and
// adds the number of discarded entries to a saturating counter.
module fetch_inst_queue #(
    parameter int PC_W   = 8,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid,
    input  logic [PC_W-1:0]   enq_pc,
    input  logic [INST_W-1:0] enq_inst,
    input  logic              enq_pred,
    output logic              enq_ready,
    output logic              deq_valid,
    output logic [PC_W-1:0]   deq_pc,
    output logic [INST_W-1:0] deq_inst,
    output logic              deq_pred,
    input  logic              deq_ready,
    output logic [PTR_W:0]    count,
    output logic [7:0]        flush_drops
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              pred_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_q;
    logic [8:0]       drop_sum;
    logic             enq_fire;
    logic             deq_fire;

    // Flush blocks both handshakes so nothing moves in the discard cycle.
    // No full pass-through and no empty bypass: both sides see only
    // registered state, keeping fetch and decode timing decoupled.
    assign enq_ready = (count_q != FULL_CNT) & ~flush;
    assign deq_valid = (count_q != '0) & ~flush;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    assign deq_pc   = deq_valid ? pc_mem[head]   : '0;
    assign deq_inst = deq_valid ? inst_mem[head] : '0;
    assign deq_pred = deq_valid ? pred_mem[head] : 1'b0;

    assign count    = count_q;
    assign drop_sum = {1'b0, flush_drops} + 9'(count_q);

    // Entry storage: written at tail on enqueue; a flush leaves contents as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                pred_mem[i] <= 1'b0;
            end
        end else if (enq_fire) begin
            pc_mem[tail]   <= enq_pc;
            inst_mem[tail] <= enq_inst;
            pred_mem[tail] <= enq_pred;
        end
    end

    // Pointers and occupancy; flush rewinds everything to an empty queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) tail <= tail + 1'b1;
            if (deq_fire) head <= head + 1'b1;
            if (enq_fire && !deq_fire)      count_q <= count_q + 1'b1;
            else if (deq_fire && !enq_fire) count_q <= count_q - 1'b1;
        end
    end

    // Saturating tally of wrong-path entries thrown away by flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_drops <= '0;
        end else if (flush) begin
            flush_drops <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Testbench for fetch_inst_queue: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_fetch_inst_queue;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic [7:0]  enq_pc;
    logic [31:0] enq_inst;
    logic        enq_pred;
    logic        enq_ready;
    logic        deq_valid;
    logic [7:0]  deq_pc;
    logic [31:0] deq_inst;
    logic        deq_pred;
    logic        deq_ready;
    logic [2:0]  count;
    logic [7:0]  flush_drops;

    int errors = 0;
    int checks = 0;

    ent_t mq[$];
    int   m_drops = 0;

    fetch_inst_queue #(.PC_W(8), .INST_W(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
        .enq_pred(enq_pred), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst),
        .deq_pred(deq_pred), .deq_ready(deq_ready),
        .count(count), .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    // Model expectations, derived from the queue contents and current flush.
    function automatic logic exp_enq_ready();
        return (mq.size() < 4) && !flush;
    endfunction

    function automatic logic exp_deq_valid();
        return (mq.size() > 0) && !flush;
    endfunction

    function automatic logic [7:0] exp_pc();
        return exp_deq_valid() ? mq[0].pc : 8'h00;
    endfunction

    function automatic logic [31:0] exp_inst();
        return exp_deq_valid() ? mq[0].inst : 32'h0;
    endfunction

    function automatic logic exp_pred();
        return exp_deq_valid() ? mq[0].pred : 1'b0;
    endfunction

    task automatic set_in(input logic f, input logic ev, input logic [7:0] pc,
                          input logic [31:0] inst, input logic pr, input logic dr);
        flush     = f;
        enq_valid = ev;
        enq_pc    = pc;
        enq_inst  = inst;
        enq_pred  = pr;
        deq_ready = dr;
    endtask

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        logic enq_ok, deq_ok, f;
        ent_t e;
        f      = flush;
        enq_ok = enq_valid && !flush && (mq.size() < 4);
        deq_ok = deq_ready && !flush && (mq.size() > 0);
        e.pc   = enq_pc;
        e.inst = enq_inst;
        e.pred = enq_pred;
        @(posedge clk);
        #1;
        if (f) begin
            m_drops = m_drops + mq.size();
            if (m_drops > 255) m_drops = 255;
            mq.delete();
        end else begin
            if (deq_ok) void'(mq.pop_front());
            if (enq_ok) mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 8'h00, 32'h0, 0, 0);
        mq.delete();
        m_drops = 0;
        #12;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (flush_drops !== 8'd0) begin errors++; $display("FAIL reset_drops got=%0d exp=0", flush_drops); end
        checks++; if (deq_pc !== 8'h00 || deq_inst !== 32'h0) begin errors++; $display("FAIL reset_deq_data got=%h/%h exp=0/0", deq_pc, deq_inst); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 8'(i), $urandom, 1'($urandom), 0);
            #1;
            checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, enq_ready); end
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
        end
        set_in(0, 1, 8'h04, $urandom, 0, 0);
        #1;
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", enq_ready); end
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (deq_pc !== 8'h00) begin errors++; $display("FAIL full_head_pc got=%h exp=00", deq_pc); end
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 8'h00, 32'h0, 0, 1);
            #1;
            checks++;
            if (deq_valid !== 1'b1 || deq_pc !== 8'(i) || deq_inst !== exp_inst() || deq_pred !== exp_pred()) begin
                errors++;
                $display("FAIL drain[%0d] got v=%b pc=%h inst=%h pred=%b exp v=1 pc=%h inst=%h pred=%b",
                         i, deq_valid, deq_pc, deq_inst, deq_pred, 8'(i), exp_inst(), exp_pred());
            end
            tick();
        end
        #1;
        checks++; if (deq_valid !== 1'b0 || deq_pc !== 8'h00) begin errors++; $display("FAIL drained got v=%b pc=%h exp v=0 pc=00", deq_valid, deq_pc); end
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, 8'(8'h10 + i), $urandom, 1'($urandom), 1);
            #1;
            checks++;
            if (deq_valid !== exp_deq_valid() || deq_pc !== exp_pc() || deq_inst !== exp_inst()) begin
                errors++;
                $display("FAIL wrap[%0d] got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         i, deq_valid, deq_pc, deq_inst, exp_deq_valid(), exp_pc(), exp_inst());
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        while (mq.size() != 2) begin
            set_in(0, mq.size() < 2, 8'h20, $urandom, 0, mq.size() > 2);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 8'(8'h30 + i), $urandom, 1'($urandom), 1);
            #1;
            checks++; if (deq_pc !== exp_pc()) begin errors++; $display("FAIL simul_pc[%0d] got=%h exp=%h", i, deq_pc, exp_pc()); end
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count[%0d] got=%0d exp=2", i, count); end
        end
        while (mq.size() != 4) begin
            set_in(0, 1, 8'h38, $urandom, 0, 0);
            tick();
        end
        set_in(0, 1, 8'h39, $urandom, 0, 1);
        #1;
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_simul_ready got=%b exp=0", enq_ready); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_simul_count got=%0d exp=3", count); end
        checks++; if (deq_pc !== exp_pc()) begin errors++; $display("FAIL full_simul_pc got=%h exp=%h", deq_pc, exp_pc()); end
    endtask

    task automatic test_flush();
        while (mq.size() != 3) begin
            set_in(0, mq.size() < 3, 8'h3A, $urandom, 0, mq.size() > 3);
            tick();
        end
        set_in(1, 1, 8'h77, $urandom, 1, 1);
        #1;
        checks++; if (enq_ready !== 1'b0 || deq_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle got rdy=%b v=%b exp 0/0", enq_ready, deq_valid); end
        checks++; if (deq_pc !== 8'h00) begin errors++; $display("FAIL flush_cycle_pc got=%h exp=00", deq_pc); end
        tick();
        set_in(0, 1, 8'h40, 32'hCAFE_0040, 1, 0);
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_flush_count got=%0d exp=0", count); end
        checks++; if (flush_drops !== 8'd3) begin errors++; $display("FAIL post_flush_drops got=%0d exp=3", flush_drops); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready got=%b exp=1", enq_ready); end
        tick();
        set_in(0, 0, 8'h00, 32'h0, 0, 0);
        #1;
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 8'h40 || deq_inst !== 32'hCAFE_0040) begin errors++; $display("FAIL corrected_pc got v=%b pc=%h inst=%h exp v=1 pc=40 inst=cafe0040", deq_valid, deq_pc, deq_inst); end
        set_in(1, 0, 8'h00, 32'h0, 0, 0);
        tick();
        tick();
        checks++; if (flush_drops !== 8'd4) begin errors++; $display("FAIL b2b_flush_drops got=%0d exp=4", flush_drops); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 64; n++) begin
            for (int i = 0; i < 4; i++) begin
                set_in(0, 1, 8'(i), $urandom, 0, 0);
                tick();
            end
            set_in(1, 0, 8'h00, 32'h0, 0, 0);
            tick();
            checks++; if (flush_drops !== 8'(m_drops)) begin errors++; $display("FAIL sat_drops[%0d] got=%0d exp=%0d", n, flush_drops, m_drops); end
        end
        checks++; if (flush_drops !== 8'hFF) begin errors++; $display("FAIL sat_reached got=%0d exp=255", flush_drops); end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 8'(i), $urandom, 0, 0);
            tick();
        end
        set_in(1, 0, 8'h00, 32'h0, 0, 0);
        tick();
        checks++; if (flush_drops !== 8'hFF) begin errors++; $display("FAIL sat_hold got=%0d exp=255", flush_drops); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 8'(8'h50 + i), $urandom, 0, 0);
            tick();
        end
        set_in(0, 0, 8'h00, 32'h0, 0, 0);
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_rst_count got=%0d exp=3", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_rst_count got=%0d exp=0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", deq_valid); end
        checks++; if (flush_drops !== 8'd0) begin errors++; $display("FAIL async_rst_drops got=%0d exp=0", flush_drops); end
        mq.delete();
        m_drops = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(15) == 0), 1'($urandom), 8'($urandom), $urandom,
                   1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (enq_ready !== exp_enq_ready() || deq_valid !== exp_deq_valid() ||
                deq_pc !== exp_pc() || deq_inst !== exp_inst() || deq_pred !== exp_pred() ||
                count !== 3'(mq.size()) || flush_drops !== 8'(m_drops)) begin
                errors++;
                $display("FAIL random[%0d] got rdy=%b v=%b pc=%h inst=%h pred=%b cnt=%0d drops=%0d exp rdy=%b v=%b pc=%h inst=%h pred=%b cnt=%0d drops=%0d",
                         c, enq_ready, deq_valid, deq_pc, deq_inst, deq_pred, count, flush_drops,
                         exp_enq_ready(), exp_deq_valid(), exp_pc(), exp_inst(), exp_pred(),
                         mq.size(), m_drops);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
